// File: rtl/multi_ch_freq_serial_out_if.sv
// -----------------------------------------------------------------------------
// multi_ch_freq_serial_out_if
// Byte stream from a UART receiver into the pattern generator.
//   data_i         : received byte, valid only while rx_done_tick_i is high
//   rx_done_tick_i : one-cycle strobe marking a new byte
// Modports: master = byte source (UART/bench), slave = pattern generator.
// -----------------------------------------------------------------------------
interface multi_ch_freq_serial_out_if;
  logic [7:0] data_i;
  logic       rx_done_tick_i;

  modport master (output data_i, output rx_done_tick_i);
  modport slave  (input  data_i, input  rx_done_tick_i);
endinterface

// File: rtl/multi_ch_freq_serial_out.sv
// -----------------------------------------------------------------------------
// multi_ch_freq_serial_out
// Receives byte packets and drives CH_NUM independent serial pattern outputs.
// Packet: DATA_BIT/8 pattern bytes, DATA_BIT/8 frequency bytes (LSB byte
// first), control {ch, idle, mode, cmd}, slow period, fast period.
// Optional build macro PKT_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   rx_if (slave)   : data_i / rx_done_tick_i byte stream
//   serial_out_o    : per-channel pattern output (idle level when IDLE)
//   bit_tick_o      : pulse on the first cycle of every bit
//   done_tick_o     : pulse on the last cycle of the last bit
//   busy_o          : channel is in RUN
//   err_tick_o      : packet rejected or timed out
// -----------------------------------------------------------------------------
module multi_ch_freq_serial_out #(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 16,
  parameter int TIMEOUT_CLK = 100000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  multi_ch_freq_serial_out_if.slave      rx_if,
  output logic [CH_NUM-1:0]              serial_out_o,
  output logic [CH_NUM-1:0]              bit_tick_o,
  output logic [CH_NUM-1:0]              done_tick_o,
  output logic [CH_NUM-1:0]              busy_o,
  output logic                           err_tick_o
);

  localparam int NB       = DATA_BIT / 8;
  localparam int PACK_NUM = 2 * NB + 3;
`ifdef PKT_CHECKSUM_EN
  localparam int PKT_LEN  = PACK_NUM + 1;
`else
  localparam int PKT_LEN  = PACK_NUM;
`endif
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLK + 1);
  localparam int IW = $clog2(DATA_BIT);

  localparam logic [CW-1:0] IDX_FREQ = CW'(NB);
  localparam logic [CW-1:0] IDX_CTRL = CW'(2 * NB);
  localparam logic [CW-1:0] IDX_SLOW = CW'(2 * NB + 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(PKT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLK - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BIT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} st_e;

  // A programmed period of 0 behaves as a one-clock bit.
  function automatic logic [7:0] eff_period(input logic [7:0] p);
    eff_period = (p == 8'd0) ? 8'd1 : p;
  endfunction

  // ---------------- packet parser ----------------
  logic [CW-1:0]       r_byte_cnt;
  logic [TW-1:0]       r_to_cnt;
  logic [DATA_BIT-1:0] r_pat_buf;
  logic [DATA_BIT-1:0] r_freq_buf;
  logic [7:0]          r_ctrl;
  logic [7:0]          r_slow;
  logic                r_err;
  logic [DATA_BIT+7:0] w_pat_shift;
  logic [DATA_BIT+7:0] w_freq_shift;
  logic [7:0]          w_fast;
  logic                w_sum_ok;
  logic                w_last;
  logic                w_valid;
  logic                w_load;
  logic                w_stop;
  logic [3:0]          w_cmd_ch;
  logic [1:0]          w_cmd;

`ifdef PKT_CHECKSUM_EN
  logic [7:0] r_fast;
  logic [7:0] r_xor;
  assign w_fast   = r_fast;
  assign w_sum_ok = (rx_if.data_i == r_xor);
`else
  assign w_fast   = rx_if.data_i;
  assign w_sum_ok = 1'b1;
`endif

  // Bytes arrive LSB first, so shifting each new byte in from the top leaves
  // the first byte in the least significant position once all have arrived.
  assign w_pat_shift  = {rx_if.data_i, r_pat_buf}  >> 8;
  assign w_freq_shift = {rx_if.data_i, r_freq_buf} >> 8;

  assign w_cmd_ch = r_ctrl[7:4];
  assign w_cmd    = r_ctrl[1:0];
  assign w_last   = rx_if.rx_done_tick_i && (r_byte_cnt == IDX_LAST);
  assign w_valid  = ((w_cmd == 2'b01) || (w_cmd == 2'b10)) &&
                    (32'(w_cmd_ch) < CH_NUM) && w_sum_ok;
  assign w_load   = w_last && w_valid && (w_cmd == 2'b01);
  assign w_stop   = w_last && w_valid && (w_cmd == 2'b10);

  // Byte counting, field capture, inter-byte timeout and error pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_pat_buf  <= '0;
      r_freq_buf <= '0;
      r_ctrl     <= 8'h00;
      r_slow     <= 8'h00;
      r_err      <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      r_fast     <= 8'h00;
      r_xor      <= 8'h00;
`endif
    end else begin
      r_err <= 1'b0;
      if (rx_if.rx_done_tick_i) begin
        r_to_cnt <= '0;
        if (w_last) begin
          r_byte_cnt <= '0;
          r_err      <= ~w_valid;
        end else begin
          r_byte_cnt <= r_byte_cnt + CW'(1);
        end
`ifdef PKT_CHECKSUM_EN
        r_xor <= w_last ? 8'h00 : (r_xor ^ rx_if.data_i);
`endif
        if (r_byte_cnt < IDX_FREQ) begin
          r_pat_buf <= w_pat_shift[DATA_BIT-1:0];
        end else if (r_byte_cnt < IDX_CTRL) begin
          r_freq_buf <= w_freq_shift[DATA_BIT-1:0];
        end else if (r_byte_cnt == IDX_CTRL) begin
          r_ctrl <= rx_if.data_i;
        end else if (r_byte_cnt == IDX_SLOW) begin
          r_slow <= rx_if.data_i;
`ifdef PKT_CHECKSUM_EN
        end else if (r_byte_cnt == IDX_SLOW + CW'(1)) begin
          r_fast <= rx_if.data_i;
`endif
        end
      end else if (r_byte_cnt != '0) begin
        // Mid-packet silence: abandon the packet after TIMEOUT_CLK clocks.
        if (r_to_cnt == TO_LAST) begin
          r_to_cnt   <= '0;
          r_byte_cnt <= '0;
          r_err      <= 1'b1;
`ifdef PKT_CHECKSUM_EN
          r_xor      <= 8'h00;
`endif
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign err_tick_o = r_err;

  // ---------------- per-channel engines ----------------
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    st_e                 r_state, w_state_nx;
    logic [DATA_BIT-1:0] r_pat, w_pat_nx, r_freq, w_freq_nx;
    logic [7:0]          r_slow_p, w_slow_nx, r_fast_p, w_fast_nx;
    logic [7:0]          r_cnt, w_cnt_nx, w_per_cur, w_per_nx;
    logic [IW-1:0]       r_idx, w_idx_nx;
    logic                r_idle, w_idle_nx, r_mode, w_mode_nx, w_sel, w_run_nx;
    logic                r_serial, r_bit_tick, r_done, r_busy;

    assign w_sel     = (w_cmd_ch == 4'(g));
    assign w_per_cur = eff_period(r_freq[r_idx] ? r_fast_p : r_slow_p);
    assign w_per_nx  = eff_period(w_freq_nx[w_idx_nx] ? w_fast_nx : w_slow_nx);
    assign w_run_nx  = (w_state_nx == ST_RUN);

    // Next-state: commands first (load preempts a run), then bit sequencing.
    always_comb begin
      w_state_nx = r_state;
      w_pat_nx   = r_pat;
      w_freq_nx  = r_freq;
      w_slow_nx  = r_slow_p;
      w_fast_nx  = r_fast_p;
      w_idle_nx  = r_idle;
      w_mode_nx  = r_mode;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt;
      if (w_load && w_sel) begin
        w_state_nx = ST_RUN;
        w_pat_nx   = r_pat_buf;
        w_freq_nx  = r_freq_buf;
        w_slow_nx  = r_slow;
        w_fast_nx  = w_fast;
        w_idle_nx  = r_ctrl[3];
        w_mode_nx  = r_ctrl[2];
        w_idx_nx   = '0;
        w_cnt_nx   = 8'd0;
      end else if (w_stop && w_sel) begin
        w_state_nx = ST_IDLE;
        w_idle_nx  = r_ctrl[3];
      end else if (r_state == ST_RUN) begin
        if (r_cnt == w_per_cur - 8'd1) begin
          w_cnt_nx = 8'd0;
          if (r_idx == BIT_LAST) begin
            w_idx_nx = '0;
            if (r_mode) begin
              w_state_nx = ST_RUN;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end else begin
        w_state_nx = ST_IDLE;
      end
    end

    // State registers; outputs are derived from next state so they line up
    // with the cycle they describe.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state    <= ST_IDLE;
        r_pat      <= '0;
        r_freq     <= '0;
        r_slow_p   <= 8'h00;
        r_fast_p   <= 8'h00;
        r_idle     <= 1'b0;
        r_mode     <= 1'b0;
        r_idx      <= '0;
        r_cnt      <= 8'd0;
        r_serial   <= 1'b0;
        r_bit_tick <= 1'b0;
        r_done     <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        r_state    <= w_state_nx;
        r_pat      <= w_pat_nx;
        r_freq     <= w_freq_nx;
        r_slow_p   <= w_slow_nx;
        r_fast_p   <= w_fast_nx;
        r_idle     <= w_idle_nx;
        r_mode     <= w_mode_nx;
        r_idx      <= w_idx_nx;
        r_cnt      <= w_cnt_nx;
        r_serial   <= w_run_nx ? w_pat_nx[w_idx_nx] : w_idle_nx;
        r_bit_tick <= w_run_nx && (w_cnt_nx == 8'd0);
        r_done     <= w_run_nx && (w_idx_nx == BIT_LAST) &&
                      (w_cnt_nx == w_per_nx - 8'd1);
        r_busy     <= w_run_nx;
      end
    end

    assign serial_out_o[g] = r_serial;
    assign bit_tick_o[g]   = r_bit_tick;
    assign done_tick_o[g]  = r_done;
    assign busy_o[g]       = r_busy;
  end

endmodule

// File: tb/tb_multi_ch_freq_serial_out.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_freq_serial_out
// Directed bench: DATA_BIT=32, CH_NUM=8, short timeout. Expected waveforms
// come from a cycle model of the bit timing written from the packet fields.
// -----------------------------------------------------------------------------
module tb_multi_ch_freq_serial_out;
  localparam int DB = 32;
  localparam int CN = 8;
  localparam int TO = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [CN-1:0] serial_out_o, bit_tick_o, done_tick_o, busy_o;
  logic          err_tick_o;
  int            n_checks = 0;
  int            n_errors = 0;

  multi_ch_freq_serial_out_if rx_if ();

  multi_ch_freq_serial_out #(.DATA_BIT(DB), .CH_NUM(CN), .TIMEOUT_CLK(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_if        (rx_if),
    .serial_out_o (serial_out_o),
    .bit_tick_o   (bit_tick_o),
    .done_tick_o  (done_tick_o),
    .busy_o       (busy_o),
    .err_tick_o   (err_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    rx_if.data_i = b;
    rx_if.rx_done_tick_i = 1'b1;
    @(posedge clk_i); #1;
    rx_if.rx_done_tick_i = 1'b0;
  endtask

  // Returns #1 after the edge that sampled the final byte.
  task automatic send_pkt(input logic [31:0] pat, input logic [31:0] freq,
                          input logic [7:0] ctrl, input logic [7:0] slow,
                          input logic [7:0] fast, input bit bad_sum);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin send_byte(pat[8*i +: 8]);  x ^= pat[8*i +: 8];  end
    for (int i = 0; i < 4; i++) begin send_byte(freq[8*i +: 8]); x ^= freq[8*i +: 8]; end
    send_byte(ctrl); x ^= ctrl;
    send_byte(slow); x ^= slow;
    send_byte(fast); x ^= fast;
`ifdef PKT_CHECKSUM_EN
    send_byte(x ^ {7'd0, bad_sum});
`else
    if (bad_sum) x = 8'h00;
`endif
  endtask

  // Cycle model of one channel, starting on the first cycle of bit 0.
  task automatic watch(input string tag, input int ch, input logic [31:0] pat,
                       input logic [31:0] freq, input int slow, input int fast,
                       input bit rpt, input bit idle, input int ncyc, input int exp_dones);
    int idx = 0, cnt = 0, per, errs = 0, dones = 0;
    bit run = 1'b1;
    logic exp_s, exp_t, exp_d;
    for (int t = 0; t < ncyc; t++) begin
      per = freq[idx] ? fast : slow;
      if (per == 0) per = 1;
      exp_s = run ? pat[idx] : idle;
      exp_t = run && (cnt == 0);
      exp_d = run && (idx == DB - 1) && (cnt == per - 1);
      if (serial_out_o[ch] !== exp_s || bit_tick_o[ch] !== exp_t ||
          done_tick_o[ch] !== exp_d || busy_o[ch] !== run) errs++;
      if (done_tick_o[ch] === 1'b1) dones++;
      if (run) begin
        if (cnt == per - 1) begin
          cnt = 0;
          if (idx == DB - 1) begin idx = 0; if (!rpt) run = 1'b0; end
          else idx++;
        end else cnt++;
      end
      @(posedge clk_i); #1;
    end
    check_val({tag, "_wave_errs"}, errs, 0);
    check_val({tag, "_dones"}, dones, exp_dones);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int errs_seen, dones_seen;
    rx_if.data_i = 8'h00;
    rx_if.rx_done_tick_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_serial", serial_out_o, 8'h00);
    check_val("rst_tick", bit_tick_o, 8'h00);
    check_val("rst_done", done_tick_o, 8'h00);
    check_val("rst_busy", busy_o, 8'h00);
    check_val("rst_err", err_tick_o, 1'b0);
    rst_ni = 1'b1;

    // ch0 one-shot, toggles every 20 clk, single done, then idle low
    send_pkt(32'h5555_5555, 32'h0, 8'h01, 8'd20, 8'd5, 1'b0);
    watch("ch0", 0, 32'h5555_5555, 32'h0, 20, 5, 1'b0, 1'b0, 650, 1);

    // ch1 repeat, 400-clk period, then stop with idle 1
    send_pkt(32'h0000_FFFF, 32'hFFFF_0000, 8'h15, 8'd20, 8'd5, 1'b0);
    watch("ch1", 1, 32'h0000_FFFF, 32'hFFFF_0000, 20, 5, 1'b1, 1'b0, 800, 2);
    send_pkt(32'h0, 32'h0, 8'h1A, 8'd0, 8'd0, 1'b0);
    check_val("ch1_stop_busy", busy_o[1], 1'b0);
    check_val("ch1_stop_serial", serial_out_o[1], 1'b1);
    dones_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_tick_o[1] === 1'b1) dones_seen++;
      @(posedge clk_i); #1;
    end
    check_val("ch1_stop_no_done", dones_seen, 0);

    // stop to an idle channel only changes its idle level
    send_pkt(32'h0, 32'h0, 8'h0A, 8'd0, 8'd0, 1'b0);
    check_val("ch0_idle_serial", serial_out_o[0], 1'b1);
    check_val("ch0_idle_busy", busy_o[0], 1'b0);
    check_val("ch0_idle_err", err_tick_o, 1'b0);

    // ch2 repeat (fast period 0 -> 1, 64-clk loop); ch3 loaded mid-run
    send_pkt(32'hA5C3_0F1E, 32'h0F0F_3355, 8'h25, 8'd3, 8'd0, 1'b0);
    fork
      watch("ch2", 2, 32'hA5C3_0F1E, 32'h0F0F_3355, 3, 0, 1'b1, 1'b0, 300, 4);
      begin
        repeat (100) @(posedge clk_i);
        #1;
        send_pkt(32'h0000_FFFF, 32'hFFFF_FFFF, 8'h39, 8'd9, 8'd2, 1'b0);
        watch("ch3", 3, 32'h0000_FFFF, 32'hFFFF_FFFF, 9, 2, 1'b0, 1'b1, 80, 1);
      end
    join

    // preempt running ch2 with a one-shot
    send_pkt(32'h0000_0001, 32'hFFFF_FFFF, 8'h21, 8'd9, 8'd1, 1'b0);
    watch("ch2p", 2, 32'h0000_0001, 32'hFFFF_FFFF, 9, 1, 1'b0, 1'b0, 40, 1);

    // rejected packets: ch 9, ch 8 (== CH_NUM), reserved cmd 11
    send_pkt(32'hFFFF_FFFF, 32'h0, 8'h91, 8'd4, 8'd4, 1'b0);
    check_val("ch9_err", err_tick_o, 1'b1);
    check_val("ch9_serial", serial_out_o, 8'h0B);
    check_val("ch9_busy", busy_o, 8'h00);
    @(posedge clk_i); #1;
    check_val("ch9_err_once", err_tick_o, 1'b0);
    send_pkt(32'hFFFF_FFFF, 32'h0, 8'h81, 8'd4, 8'd4, 1'b0);
    check_val("ch8_err", err_tick_o, 1'b1);
    check_val("ch8_busy", busy_o, 8'h00);
    send_pkt(32'hFFFF_FFFF, 32'h0, 8'h03, 8'd4, 8'd4, 1'b0);
    check_val("cmd11_err", err_tick_o, 1'b1);
    check_val("cmd11_serial", serial_out_o, 8'h0B);

    // timeout after 5 bytes, then a normal packet to ch4
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    errs_seen = 0;
    for (int i = 0; i < TO + 16; i++) begin
      if (err_tick_o === 1'b1) errs_seen++;
      @(posedge clk_i); #1;
    end
    check_val("timeout_err_cnt", errs_seen, 1);
    send_pkt(32'h0000_0001, 32'h0, 8'h41, 8'd1, 8'd1, 1'b0);
    check_val("after_to_err", err_tick_o, 1'b0);
    watch("ch4", 4, 32'h0000_0001, 32'h0, 1, 1, 1'b0, 1'b0, 40, 1);

`ifdef PKT_CHECKSUM_EN
    send_pkt(32'h0000_00FF, 32'h0, 8'h61, 8'd2, 8'd2, 1'b1);
    check_val("sum_bad_err", err_tick_o, 1'b1);
    check_val("sum_bad_busy", busy_o[6], 1'b0);
    send_pkt(32'h0000_00FF, 32'h0, 8'h61, 8'd2, 8'd2, 1'b0);
    check_val("sum_ok_err", err_tick_o, 1'b0);
    check_val("sum_ok_busy", busy_o[6], 1'b1);
`endif

    // reset mid-run on ch5 clears everything without ticks
    send_pkt(32'hFFFF_FFFF, 32'h0, 8'h55, 8'd4, 8'd4, 1'b0);
    check_val("ch5_busy", busy_o[5], 1'b1);
    repeat (6) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check_val("mid_rst_serial", serial_out_o, 8'h00);
    check_val("mid_rst_busy", busy_o, 8'h00);
    check_val("mid_rst_tick", bit_tick_o | done_tick_o, 8'h00);
    check_val("mid_rst_err", err_tick_o, 1'b0);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check_val("post_rst_serial", serial_out_o, 8'h00);
    check_val("post_rst_busy", busy_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
